// File: rtl/fir_host_master.sv
// Host-side sequencer for the FIR accelerator: programs length and taps over
// AXI-Lite, streams samples out, collects results and polls ap_done.
module fir_host_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [31:0]            len,
    output logic                   busy,
    output logic                   done,
    output logic [pADDR_WIDTH-1:0] coef_A,
    input  logic [pDATA_WIDTH-1:0] coef_Do,
    output logic [pADDR_WIDTH-1:0] smp_A,
    input  logic [pDATA_WIDTH-1:0] smp_Do,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready,
    output logic [31:0]            y_cnt,
    output logic [31:0]            y_sum,
    output logic                   err_last,
    output logic                   err_timeout
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_LEN    = 3'd1;
    localparam logic [2:0] TAP_FETCH = 3'd2;
    localparam logic [2:0] WR_TAP    = 3'd3;
    localparam logic [2:0] WR_START  = 3'd4;
    localparam logic [2:0] STREAM    = 3'd5;
    localparam logic [2:0] POLL      = 3'd6;
    localparam logic [2:0] FIN       = 3'd7;

    localparam int TAP_W = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
    localparam logic [TAP_W-1:0]       TAP_LAST  = TAP_W'(Tape_Num - 1);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h0000_0000);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h0000_0010);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(32'h0000_0020);
    localparam logic [pADDR_WIDTH-1:0] ADDR_ZERO = {pADDR_WIDTH{1'b0}};
    localparam logic [10:0]            POLL_MAX  = 11'd1024;

    logic [2:0]       state_r;
    logic [31:0]      len_r;
    logic [TAP_W-1:0] tap_idx_r;
    logic             tap_cap_r;
    logic [31:0]      snd_k_r;
    logic             snd_fetch_r;
    logic             snd_done_r;
    logic [10:0]      poll_cnt_r;

    logic             wr_fin_s;
    logic             rcv_beat_s;
    logic             last_exp_s;
    logic [31:0]      snd_k_nxt_s;
    logic [10:0]      poll_cnt_nxt_s;
    logic             unused_s;

    // A write retires once each of its two handshakes has happened, in any order.
    assign wr_fin_s       = (!awvalid || awready) && (!wvalid || wready);
    assign sm_tready      = ((state_r == STREAM) || (state_r == POLL)) && (y_cnt < len_r);
    assign rcv_beat_s     = sm_tvalid && sm_tready;
    assign last_exp_s     = (y_cnt == (len_r - 32'd1));
    assign snd_k_nxt_s    = snd_k_r + 32'd1;
    assign poll_cnt_nxt_s = poll_cnt_r + 11'd1;
    // Sample RAM output is registered, so holding smp_A keeps the beat stable.
    assign ss_tdata       = smp_Do;
    assign unused_s       = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};

    // Sequencer, AXI-Lite master channels, sample sender and result collector.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_r     <= IDLE;
            len_r       <= 32'd0;
            tap_idx_r   <= {TAP_W{1'b0}};
            tap_cap_r   <= 1'b0;
            snd_k_r     <= 32'd0;
            snd_fetch_r <= 1'b0;
            snd_done_r  <= 1'b0;
            poll_cnt_r  <= 11'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            coef_A      <= ADDR_ZERO;
            smp_A       <= ADDR_ZERO;
            awvalid     <= 1'b0;
            awaddr      <= ADDR_ZERO;
            wvalid      <= 1'b0;
            wdata       <= {pDATA_WIDTH{1'b0}};
            arvalid     <= 1'b0;
            araddr      <= ADDR_ZERO;
            rready      <= 1'b0;
            ss_tvalid   <= 1'b0;
            ss_tlast    <= 1'b0;
            y_cnt       <= 32'd0;
            y_sum       <= 32'd0;
            err_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (rcv_beat_s) begin
                y_cnt <= y_cnt + 32'd1;
                y_sum <= y_sum + 32'(sm_tdata);
                if (sm_tlast != last_exp_s) err_last <= 1'b1;
            end
            case (state_r)
                IDLE: if (start) begin
                    len_r       <= len;
                    y_cnt       <= 32'd0;
                    y_sum       <= 32'd0;
                    err_last    <= 1'b0;
                    err_timeout <= 1'b0;
                    busy        <= 1'b1;
                    awvalid     <= 1'b1;
                    awaddr      <= ADDR_LEN;
                    wvalid      <= 1'b1;
                    wdata       <= pDATA_WIDTH'(len);
                    state_r     <= WR_LEN;
                end
                WR_LEN: if (wr_fin_s) begin
                    coef_A    <= ADDR_ZERO;
                    tap_idx_r <= {TAP_W{1'b0}};
                    state_r   <= TAP_FETCH;
                end
                TAP_FETCH: begin
                    tap_cap_r <= 1'b0;
                    state_r   <= WR_TAP;
                end
                WR_TAP: if (!tap_cap_r) begin
                    tap_cap_r <= 1'b1;
                    awvalid   <= 1'b1;
                    awaddr    <= ADDR_TAP0 + pADDR_WIDTH'({tap_idx_r, 2'b00});
                    wvalid    <= 1'b1;
                    wdata     <= coef_Do;
                end else if (wr_fin_s) begin
                    if (tap_idx_r == TAP_LAST) begin
                        awvalid <= 1'b1;
                        awaddr  <= ADDR_CTRL;
                        wvalid  <= 1'b1;
                        wdata   <= pDATA_WIDTH'(32'h0000_0001);
                        state_r <= WR_START;
                    end else begin
                        tap_idx_r <= tap_idx_r + TAP_W'(32'd1);
                        coef_A    <= pADDR_WIDTH'(tap_idx_r + TAP_W'(32'd1));
                        state_r   <= TAP_FETCH;
                    end
                end
                WR_START: if (wr_fin_s) begin
                    if (len_r == 32'd0) begin
                        arvalid    <= 1'b1;
                        araddr     <= ADDR_CTRL;
                        poll_cnt_r <= 11'd0;
                        state_r    <= POLL;
                    end else begin
                        smp_A       <= ADDR_ZERO;
                        snd_k_r     <= 32'd0;
                        snd_fetch_r <= 1'b1;
                        snd_done_r  <= 1'b0;
                        state_r     <= STREAM;
                    end
                end
                STREAM: begin
                    if (snd_fetch_r) begin
                        snd_fetch_r <= 1'b0;
                        ss_tvalid   <= 1'b1;
                        ss_tlast    <= (snd_k_r == (len_r - 32'd1));
                    end else if (ss_tvalid && ss_tready) begin
                        ss_tvalid <= 1'b0;
                        ss_tlast  <= 1'b0;
                        if (snd_k_nxt_s < len_r) begin
                            snd_k_r     <= snd_k_nxt_s;
                            smp_A       <= pADDR_WIDTH'(snd_k_nxt_s);
                            snd_fetch_r <= 1'b1;
                        end else begin
                            snd_done_r <= 1'b1;
                        end
                    end
                    if (snd_done_r && (y_cnt == len_r)) begin
                        arvalid    <= 1'b1;
                        araddr     <= ADDR_CTRL;
                        poll_cnt_r <= 11'd0;
                        state_r    <= POLL;
                    end
                end
                POLL: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                    if (rready && rvalid) begin
                        rready     <= 1'b0;
                        poll_cnt_r <= poll_cnt_nxt_s;
                        if (rdata[1]) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= FIN;
                        end else if (poll_cnt_nxt_s == POLL_MAX) begin
                            err_timeout <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state_r     <= FIN;
                        end else begin
                            arvalid <= 1'b1;
                        end
                    end
                end
                FIN:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_host_master.sv
// Directed bench for fir_host_master: bus-slave, RAM and stream-sink models
// driven cycle by cycle, with hand-computed expected values.
module tb_fir_host_master;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        start;
    logic [31:0] len;
    logic        busy, done;
    logic [11:0] coef_A, smp_A, awaddr, araddr;
    logic [31:0] coef_Do, smp_Do, wdata, rdata, ss_tdata, sm_tdata, y_cnt, y_sum;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic        ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
    logic        err_last, err_timeout;

    always #5 axis_clk = ~axis_clk;

    fir_host_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .len(len),
        .busy(busy), .done(done), .coef_A(coef_A), .coef_Do(coef_Do),
        .smp_A(smp_A), .smp_Do(smp_Do),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .y_cnt(y_cnt), .y_sum(y_sum), .err_last(err_last), .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int taps[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    int          coef_a_q, smp_a_q;
    bit          skew_mode;
    int          w_age;
    logic [31:0] w_first;
    bit          aw_got, w_got;
    logic [11:0] aw_val;
    logic [31:0] w_val;
    logic [11:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    bit          rd_pend;
    int          n_reads;
    logic [31:0] poll_q[$];
    logic [31:0] poll_default;
    int          cur_len, stall_at, stall_cnt, sink_last;
    int          ss_beats, res_idx;
    int          done_cnt, done_wide, excl_viol;
    logic        done_prev;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_bench();
        aw_got = 1'b0; w_got = 1'b0; w_age = 0; rd_pend = 1'b0; n_reads = 0;
        wlog_addr.delete(); wlog_data.delete(); poll_q.delete(); poll_default = 32'h0;
        ss_beats = 0; res_idx = 0; stall_cnt = 0; stall_at = -1; skew_mode = 1'b0;
    endtask

    // One clock: update RAM models, drive slave inputs, then account handshakes
    // that the coming edge will complete.
    task automatic tick();
        @(posedge axis_clk);
        #1;
        coef_Do  = $unsigned(taps[(coef_a_q < 11) ? coef_a_q : 0]);
        smp_Do   = 32'(smp_a_q + 1);
        coef_a_q = int'(coef_A);
        smp_a_q  = int'(smp_A);
        #1;
        awready   = 1'b1;
        wready    = skew_mode ? (w_age >= 3) : 1'b1;
        arready   = 1'b1;
        rvalid    = rd_pend;
        rdata     = (poll_q.size() > 0) ? poll_q[0] : poll_default;
        ss_tready = !((ss_beats == stall_at) && (stall_cnt < 5));
        if ((ss_beats == stall_at) && (stall_cnt < 5)) stall_cnt++;
        sm_tvalid = (res_idx < ss_beats);
        sm_tdata  = 32'(10 * (res_idx + 1));
        sm_tlast  = (res_idx == sink_last);
        #1;
        if (awvalid && arvalid) excl_viol++;
        if (done) begin
            done_cnt++;
            if (done_prev) done_wide++;
        end
        done_prev = done;
        if (wvalid && (w_age == 0)) w_first = wdata;
        if (awvalid && awready) begin aw_got = 1'b1; aw_val = awaddr; end
        if (wvalid && wready) begin
            if (w_age > 0) check_eq("wdata_stable", wdata, w_first);
            w_got = 1'b1; w_val = wdata;
        end
        if (aw_got && w_got) begin
            wlog_addr.push_back(aw_val); wlog_data.push_back(w_val);
            aw_got = 1'b0; w_got = 1'b0;
        end
        if (wvalid && !wready) w_age++; else w_age = 0;
        if (rvalid && rready) begin
            rd_pend = 1'b0; n_reads++;
            if (poll_q.size() > 0) void'(poll_q.pop_front());
        end
        if (arvalid && arready) rd_pend = 1'b1;
        if (ss_tvalid && !ss_tready) check_eq("ss_hold", ss_tdata, 32'(ss_beats + 1));
        if (ss_tvalid && ss_tready) begin
            check_eq("ss_tdata", ss_tdata, 32'(ss_beats + 1));
            check_eq("ss_tlast", ss_tlast, (ss_beats == cur_len - 1));
            ss_beats++;
        end
        if (sm_tvalid && sm_tready) res_idx++;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_flags"}, {busy, done, awvalid, wvalid, arvalid, rready,
                                   ss_tvalid, ss_tlast, sm_tready, err_last, err_timeout}, 64'd0);
        check_eq({tag, "_y_cnt"}, y_cnt, 64'd0);
        check_eq({tag, "_y_sum"}, y_sum, 64'd0);
        check_eq({tag, "_addr"}, {coef_A, smp_A}, 64'd0);
    endtask

    task automatic start_run(input logic [31:0] n);
        cur_len = int'(n);
        start = 1'b1; len = n;
        tick();
        start = 1'b0;
        check_eq("busy_on_start", busy, 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt; n = 0;
        while ((done_cnt == d0) && (n < budget)) begin tick(); n++; end
        check_eq({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        tick();
        check_eq({tag, "_done_pulse"}, done, 64'd0);
        check_eq({tag, "_busy_low"}, busy, 64'd0);
    endtask

    task automatic check_write(input int i, input logic [11:0] a, input logic [31:0] d);
        if (wlog_addr.size() > i) begin
            check_eq($sformatf("wr%0d_addr", i), wlog_addr[i], a);
            check_eq($sformatf("wr%0d_data", i), wlog_data[i], d);
        end else begin
            check_eq($sformatf("wr%0d_present", i), 64'(wlog_addr.size()), 64'(i + 1));
        end
    endtask

    initial begin
        int n;
        axis_rst_n = 1'b0; start = 1'b0; len = 32'd0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = 32'd0; sm_tlast = 1'b0;
        coef_Do = 32'd0; smp_Do = 32'd0; coef_a_q = 0; smp_a_q = 0;
        done_cnt = 0; done_wide = 0; excl_viol = 0; done_prev = 1'b0;
        cur_len = 0; sink_last = -1;
        clear_bench();
        repeat (2) tick();
        check_reset_outs("rst_init");
        axis_rst_n = 1'b1;
        tick();

        // Tap load with len=600, then reset in the middle of the stream.
        clear_bench(); sink_last = 599;
        start_run(32'd600);
        n = 0;
        while ((wlog_addr.size() < 13) && (n < 300)) begin tick(); n++; end
        check_write(0, 12'h010, 32'd600);
        for (int i = 0; i < 11; i++) check_write(i + 1, 12'(32'h20 + 4 * i), $unsigned(taps[i]));
        check_write(12, 12'h000, 32'd1);
        n = 0;
        while ((ss_beats < 3) && (n < 50)) begin tick(); n++; end
        check_eq("stream_started", 64'(ss_beats >= 3), 64'd1);
        check_eq("busy_mid_stream", busy, 64'd1);
        axis_rst_n = 1'b0;
        tick();
        check_reset_outs("rst_mid");
        axis_rst_n = 1'b1;
        tick();

        // len=0 with skewed write ready and a three-read poll sequence.
        clear_bench(); skew_mode = 1'b1; sink_last = -1;
        poll_q.push_back(32'h4); poll_q.push_back(32'h4); poll_q.push_back(32'h6);
        start_run(32'd0);
        wait_done("len0", 800);
        check_eq("len0_nwrites", 64'(wlog_addr.size()), 64'd13);
        check_write(0, 12'h010, 32'd0);
        check_write(4, 12'h02C, 32'd23);
        check_write(12, 12'h000, 32'd1);
        check_eq("len0_no_beats", 64'(ss_beats), 64'd0);
        check_eq("len0_reads", 64'(n_reads), 64'd3);

        // Four-sample stream with mid-stream backpressure and an ignored start.
        clear_bench(); stall_at = 2; sink_last = 3; poll_q.push_back(32'h2);
        start_run(32'd4);
        repeat (3) tick();
        start = 1'b1; len = 32'd9;
        tick();
        start = 1'b0;
        wait_done("s4", 400);
        check_eq("s4_nwrites", 64'(wlog_addr.size()), 64'd13);
        check_write(0, 12'h010, 32'd4);
        check_eq("s4_beats", 64'(ss_beats), 64'd4);
        check_eq("s4_stalls", 64'(stall_cnt), 64'd5);
        check_eq("s4_y_cnt", y_cnt, 64'd4);
        check_eq("s4_y_sum", y_sum, 64'd100);
        check_eq("s4_err_last", err_last, 64'd0);
        check_eq("s4_reads", 64'(n_reads), 64'd1);

        // Sink raises tlast one result early.
        clear_bench(); sink_last = 2; poll_q.push_back(32'h2);
        start_run(32'd4);
        wait_done("bad_last", 400);
        check_eq("bad_last_err", err_last, 64'd1);
        check_eq("bad_last_y_cnt", y_cnt, 64'd4);

        // ap_done never rises: timeout after 1024 reads.
        clear_bench(); sink_last = -1;
        start_run(32'd0);
        check_eq("err_last_cleared", err_last, 64'd0);
        wait_done("tmo", 6000);
        check_eq("tmo_reads", 64'(n_reads), 64'd1024);
        check_eq("tmo_err", err_timeout, 64'd1);

        check_eq("aw_ar_exclusive", 64'(excl_viol), 64'd0);
        check_eq("done_one_cycle", 64'(done_wide), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fir_host_master.md
FIR_HOST_MASTER -- requirements
Module: fir_host_master

Interface
REQ-001 SHALL have parameters: pADDR_WIDTH, default 12, AXI-Lite address width; pDATA_WIDTH, default 32, data width; Tape_Num, default 11, tap count.
REQ-002 SHALL have the ports below, one per line as name, direction, width, meaning:
- axis_clk  in  1  sole clock.
- axis_rst_n  in  1  reset, synchronous and active-low.
- start  in  1  run request, sampled in IDLE.
- len  in  32  sample count, latched on start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- coef_A  out  pADDR_WIDTH  tap source word index.
- coef_Do  in  32  tap source data, 1-cycle read latency.
- smp_A  out  pADDR_WIDTH  sample source word index.
- smp_Do  in  32  sample source data, 1-cycle read latency.
- awvalid/awaddr, wvalid/wdata  out  1/pADDR_WIDTH, 1/32  AXI-Lite write master.
- awready, wready  in  1  AXI-Lite write ready.
- arvalid/araddr, rready  out  1/pADDR_WIDTH, 1  AXI-Lite read master.
- arready, rvalid, rdata  in  1, 1, 32  AXI-Lite read slave responses.
- ss_tvalid, ss_tdata, ss_tlast  out  1, 32, 1  AXI-Stream sample master.
- ss_tready  in  1  AXI-Stream sample ready.
- sm_tvalid, sm_tdata, sm_tlast  in  1, 32, 1  AXI-Stream result slave.
- sm_tready  out  1  AXI-Stream result ready.
- y_cnt  out  32  results received.
- y_sum  out  32  wrap-around sum of results.
- err_last  out  1  sticky tlast mismatch.
- err_timeout  out  1  sticky poll timeout.

Function
REQ-003 SHALL target the FIR register map: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle), 0x10 data_length, 0x20+4*i tap i for i=0..Tape_Num-1.
REQ-004 SHALL use states IDLE, WR_LEN, TAP_FETCH, WR_TAP, WR_START, STREAM, POLL, FIN.
REQ-005 IDLE: start=1 -> latch len, clear y_cnt/y_sum/err_*, busy=1, go WR_LEN; start while busy SHALL be ignored.
REQ-006 Each AXI-Lite write SHALL raise awvalid and wvalid in the same cycle, hold each until its own ready is sampled high, and complete when both handshakes are done, in either order or together; there is no B channel.
REQ-007 awaddr/wdata SHALL stay stable while the corresponding valid is high.
REQ-008 WR_LEN SHALL write len to 0x10, then go TAP_FETCH with coef_A=0.
REQ-009 TAP_FETCH SHALL present coef_A=i for one cycle; WR_TAP SHALL write the captured coef_Do to 0x20+4*i; after i=Tape_Num-1, go WR_START.
REQ-010 WR_START SHALL write 0x00000001 to 0x00, then go STREAM, or go POLL when len=0.
REQ-011 STREAM sender: fetch smp_A=k, assert ss_tvalid next cycle with smp_Do, and hold data until ss_tready; ss_tlast SHALL be 1 only on beat k=len-1; the maximum rate is one beat per 2 cycles.
REQ-012 sm_tready SHALL be 1 in STREAM and POLL while y_cnt<len; each sm_tvalid&&sm_tready beat SHALL increment y_cnt and add sm_tdata to y_sum modulo 2^32.
REQ-013 err_last SHALL set when a beat has sm_tlast=1 with y_cnt!=len-1, or sm_tlast=0 with y_cnt=len-1.
REQ-014 STREAM SHALL exit to POLL when all len beats are sent and y_cnt=len.
REQ-015 POLL SHALL read 0x00: hold arvalid until arready, then hold rready=1 until rvalid; rdata bit1=1 -> FIN, otherwise re-issue the read.
REQ-016 After 1024 poll reads without bit1, the block SHALL set err_timeout and go FIN.
REQ-017 FIN SHALL drive done=1 for one cycle and busy=0, then go IDLE.
REQ-018 At most one of awvalid or arvalid SHALL be active at any time.

Reset
REQ-019 With axis_rst_n=0 sampled at a clock edge, the block SHALL enter IDLE and drive every valid, ready, done, busy, err_*, y_cnt, y_sum, coef_A and smp_A to 0 on the next cycle, including when reset arrives mid-transaction.

Verification
REQ-020 Tap load: len=600, taps 0,-10,-9,23,56,63,56,23,-9,-10,0, awready/wready always 1 -> writes 0x10=600, 0x20..0x48 in order, then 0x00=1.
REQ-021 Skewed ready: wready 3 cycles after awready -> wdata stable, single write counted, no duplicate.
REQ-022 Stream: len=4, samples 1,2,3,4, sink returns 10,20,30,40 with tlast on 40 -> y_cnt=4, y_sum=100, err_last=0, ss_tlast only on sample 4.
REQ-023 Backpressure: ss_tready low 5 cycles mid-stream -> ss_tdata held, no lost or duplicate beats.
REQ-024 Poll: rdata=0x4 twice then 0x6 -> exactly 3 reads, done pulse 1 cycle; rdata stuck at 0 -> err_timeout=1 after 1024 reads.
REQ-025 Reset mid-STREAM -> all outputs 0 next cycle; a subsequent start with len=0 -> no stream beats, poll, done.
